// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and GF(2^8) helpers for the inverse cipher
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
    typedef logic [127:0] block_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); it maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // inverse affine transform followed by field inversion
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] y;
        y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/add_round_key.sv
// add_round_key: XORs the round key into the state
module add_round_key
    import aes_pkg::*;
(
    input  block_t din,
    input  block_t rk,
    output block_t dout
);
    assign dout = din ^ rk;
endmodule

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; skip_mix drops InvMixColumns for the last round
module aes_inv_round
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t rk,
    input  logic   skip_mix,
    output block_t state_out
);
    block_t sr;
    block_t sb;
    block_t ark;
    block_t mc;

    inv_shift_rows  u_sr  (.din(state_in), .dout(sr));
    inv_sub_bytes   u_sb  (.din(sr), .dout(sb));
    add_round_key   u_ark (.din(sb), .rk(rk), .dout(ark));
    inv_mix_columns u_mc  (.din(ark), .dout(mc));

    assign state_out = skip_mix ? ark : mc;
endmodule

// File: rtl/inv_mix_columns.sv
// inv_mix_columns: multiplies each state column by the {0e,0b,0d,09} circulant matrix
module inv_mix_columns
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);
    for (genvar c = 0; c < 4; c++) begin : g_c
        for (genvar i = 0; i < 4; i++) begin : g_i
            assign dout[127-8*(4*c+i) -: 8] =
                gmul(din[127-8*(4*c+i) -: 8], 8'h0e) ^
                gmul(din[127-8*(4*c+(i+1)%4) -: 8], 8'h0b) ^
                gmul(din[127-8*(4*c+(i+2)%4) -: 8], 8'h0d) ^
                gmul(din[127-8*(4*c+(i+3)%4) -: 8], 8'h09);
        end
    end
endmodule

// File: rtl/inv_shift_rows.sv
// inv_shift_rows: rotates row r of the column-major state right by r bytes
module inv_shift_rows
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);
    for (genvar r = 0; r < 4; r++) begin : g_r
        for (genvar c = 0; c < 4; c++) begin : g_c
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+4-r)%4)) -: 8];
        end
    end
endmodule

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: applies the inverse S-box to every state byte
module inv_sub_bytes
    import aes_pkg::*;
(
    input  block_t din,
    output block_t dout
);
    for (genvar b = 0; b < 16; b++) begin : g_b
        assign dout[8*b+7 -: 8] = inv_sbox(din[8*b+7 -: 8]);
    end
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// aes_inv_cipher_ctrl: iterative AES decryption sequencer, one inverse round per clock
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR  = NR_AES128,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [RKW-1:0] rk_addr,
    input  logic [127:0]   rk_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           busy
);
    state_t         st;
    state_t         st_n;
    logic [RKW-1:0] rnd;
    block_t         state_q;
    block_t         rnd_out;

    assign in_ready  = st == IDLE;
    assign out_valid = st == DONE;
    assign busy      = st == ROUND || st == FINAL;
    assign out_data  = state_q;
    assign rk_addr   = st == IDLE ? RKW'(NR) : st == ROUND ? rnd : '0;

    aes_inv_round u_round (
        .state_in (state_q),
        .rk       (rk_data),
        .skip_mix (st == FINAL),
        .state_out(rnd_out)
    );

    // next state: ROUND is skipped entirely when there is only one round
    always_comb begin
        st_n = st == IDLE  ? (in_valid ? (NR == 1 ? FINAL : ROUND) : IDLE)
             : st == ROUND ? (rnd == RKW'(1) ? FINAL : ROUND)
             : st == FINAL ? DONE
             : (out_ready ? IDLE : DONE);
    end

    // state register, round counter and cipher state; the initial AddRoundKey happens on capture
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            rnd     <= '0;
            state_q <= '0;
        end else begin
            st <= st_n;
            if (st == IDLE && in_valid) begin
                state_q <= in_data ^ rk_data;
                rnd     <= RKW'(NR - 1);
            end else if (busy) begin
                state_q <= rnd_out;
                if (st == ROUND) rnd <= rnd - RKW'(1);
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// tb_aes_inv_cipher_ctrl: directed and random decryption checks against a forward-AES reference model
module tb_aes_inv_cipher_ctrl;

    logic         clk = 0;
    logic         rst = 1;
    logic         in_valid = 0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready = 0;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad = 0;

    logic [7:0]   sb [256];
    logic [127:0] ks [16];

    aes_inv_cipher_ctrl #(.NR(10), .RKW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_addr(rk_addr), .rk_data(rk_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    assign rk_data = ks[rk_addr];

    always #5 clk = ~clk;

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // forward AES-128 encryption with the expanded key in ks
    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        logic [127:0] k;
        k = ks[0];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++)
                    s[4*c+i] = (r == 10) ? t[4*c+i] :
                        mul(t[4*c+i], 8'h02) ^ mul(t[4*c+(i+1)%4], 8'h03) ^ t[4*c+(i+2)%4] ^ t[4*c+(i+3)%4];
            k = ks[r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one full block: accept, round-by-round key address, result, optional backpressure, handshake
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input logic [127:0] first,
                             input int hold, input bit poke, input string tag);
        logic   stable;
        int     n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk({tag, "_ready"}, 128'(in_ready), 128'(1));
        chk({tag, "_rk_idle"}, 128'(rk_addr), 128'(10));
        in_valid = 1;
        in_data  = ct;
        step();
        in_valid = 0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        chk({tag, "_first"}, out_data, first);
        chk({tag, "_busy"}, 128'({busy, in_ready}), 128'(2'b10));
        for (int i = 1; i <= 9; i++) begin
            chk({tag, "_rk_round"}, 128'({out_valid, rk_addr}), 128'(10 - i));
            if (poke && i == 5) begin
                in_valid = 1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            in_valid = 0;
        end
        chk({tag, "_rk_final"}, 128'({out_valid, busy, rk_addr}), 128'({1'b0, 1'b1, 4'd0}));
        step();
        chk({tag, "_valid"}, 128'({out_valid, busy, in_ready}), 128'(3'b100));
        chk({tag, "_data"}, out_data, pt);
        stable = 1;
        out_ready = 0;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_data === pt)) stable = 0;
        end
        if (hold > 0) chk({tag, "_hold"}, 128'(stable), 128'(1));
        out_ready = 1;
        step();
        out_ready = 0;
        chk({tag, "_release"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] fips_ct;
        logic [127:0] fips_pt;
        logic [127:0] pt;
        logic [127:0] ct;
        logic [127:0] pt2;
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   inv;
        logic         seen;
        int           n;

        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                    {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        key = 128'h000102030405060708090a0b0c0d0e0f;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) ks[r] = r < 11 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
        fips_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        fips_pt = 128'h00112233445566778899aabbccddeeff;

        // reset held two cycles
        rst = 1;
        step();
        step();
        chk("reset_hold", 128'({in_ready, out_valid, busy, rk_addr}), 128'({3'b100, 4'd10}));
        chk("reset_data", out_data, '0);
        rst = 0;

        // reference vector, with a short backpressure window and an ignored pulse
        run_block(fips_ct, fips_pt, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 5, 1, "fips");

        // random blocks encrypted by the model
        for (int j = 0; j < 4; j++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = enc(pt);
            run_block(ct, pt, ct ^ ks[10], int'($urandom_range(0, 3)), j[0], "rand");
        end

        // back-to-back with in_valid held high across both blocks
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1;
        in_data  = fips_ct;
        step();
        in_data = enc(pt2);
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("b2b_lat1", 128'(n), 128'(10));
        chk("b2b_data1", out_data, fips_pt);
        out_ready = 1;
        step();
        chk("b2b_idle", 128'({in_ready, rk_addr}), 128'({1'b1, 4'd10}));
        step();
        in_valid = 0;
        out_ready = 0;
        chk("b2b_accept2", 128'({in_ready, busy, rk_addr}), 128'({2'b01, 4'd9}));
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("b2b_lat2", 128'(n), 128'(10));
        chk("b2b_data2", out_data, pt2);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("b2b_release", 128'({out_valid, in_ready}), 128'(2'b01));

        // reset in the middle of ROUND discards the block
        in_valid = 1;
        in_data  = fips_ct;
        step();
        in_valid = 0;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_busy", 128'(busy), 128'(1));
        rst = 1;
        out_ready = 1;
        step();
        rst = 0;
        chk("midrst_ctrl", 128'({in_ready, out_valid, busy, rk_addr}), 128'({3'b100, 4'd10}));
        chk("midrst_data", out_data, '0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        out_ready = 0;
        chk("midrst_quiet", 128'(seen), 128'(0));

        // reset beats a same-cycle input handshake
        rst = 1;
        in_valid = 1;
        in_data = fips_ct;
        step();
        rst = 0;
        in_valid = 0;
        chk("rst_priority", 128'({in_ready, busy}), 128'(2'b10));
        chk("rst_prio_data", out_data, '0);

        run_block(fips_ct, fips_pt, fips_ct ^ ks[10], 0, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
